// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the multicycle control FSM and the MIPS-subset datapath.
// master = control unit (consumes op/flags, drives enables and selects); slave = datapath.
interface multicycle_control_unit_if;
  logic [5:0] op;
  logic       zero;
  logic       sign;
  logic [2:0] state;
  logic       PCWre;
  logic       IRWre;
  logic       InsMemRW;
  logic       RegWre;
  logic       mRD;
  logic       mWR;
  logic       ALUSrcA;
  logic       ALUSrcB;
  logic       DBDataSrc;
  logic       WrRegDSrc;
  logic       ExtSel;
  logic [1:0] RegDst;
  logic [1:0] PCSrc;
  logic [2:0] ALUOp;
  logic       halted;

  modport master (
    input  op, zero, sign,
    output state, PCWre, IRWre, InsMemRW, RegWre, mRD, mWR, ALUSrcA, ALUSrcB,
           DBDataSrc, WrRegDSrc, ExtSel, RegDst, PCSrc, ALUOp, halted
  );

  modport slave (
    output op, zero, sign,
    input  state, PCWre, IRWre, InsMemRW, RegWre, mRD, mWR, ALUSrcA, ALUSrcB,
           DBDataSrc, WrRegDSrc, ExtSel, RegDst, PCSrc, ALUOp, halted
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle IF/ID/EXE/MEM/WB sequencer for the MIPS-subset CPU; the state is registered,
// and all datapath controls are decoded combinationally from state, op and the ALU flags.
module multicycle_control_unit (
  input logic                       CLK,
  input logic                       Reset,
  multicycle_control_unit_if.master bus
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  state_t cur;

  logic       is_alu, is_imm, is_sw, is_lw, is_br, is_jmp, is_jtgt, is_jr, is_jal;
  logic       is_halt, is_sll, is_zext, taken, known;
  logic [2:0] alu_op;

  // Opcode classification; taken is only meaningful for branches during EXE.
  always_comb begin
    is_alu  = 1'b0;
    is_imm  = 1'b0;
    is_sw   = 1'b0;
    is_lw   = 1'b0;
    is_br   = 1'b0;
    is_jmp  = 1'b0;
    is_jtgt = 1'b0;
    is_jr   = 1'b0;
    is_jal  = 1'b0;
    is_halt = 1'b0;
    is_sll  = 1'b0;
    is_zext = 1'b0;
    taken   = 1'b0;
    alu_op  = 3'b000;
    case (bus.op)
      6'b000000: is_alu = 1'b1;
      6'b000001: begin is_alu = 1'b1; alu_op = 3'b001; end
      6'b011000: begin is_alu = 1'b1; is_sll = 1'b1; alu_op = 3'b010; end
      6'b010000: begin is_alu = 1'b1; alu_op = 3'b011; end
      6'b010001: begin is_alu = 1'b1; alu_op = 3'b100; end
      6'b100110: begin is_alu = 1'b1; alu_op = 3'b101; end
      6'b000010: is_imm = 1'b1;
      6'b010010: begin is_imm = 1'b1; is_zext = 1'b1; alu_op = 3'b011; end
      6'b010011: begin is_imm = 1'b1; is_zext = 1'b1; alu_op = 3'b100; end
      6'b010100: begin is_imm = 1'b1; is_zext = 1'b1; alu_op = 3'b110; end
      6'b100111: begin is_imm = 1'b1; alu_op = 3'b101; end
      6'b110000: is_sw = 1'b1;
      6'b110001: is_lw = 1'b1;
      6'b110100: begin is_br = 1'b1; alu_op = 3'b001; taken = bus.zero; end
      6'b110101: begin is_br = 1'b1; alu_op = 3'b001; taken = ~bus.zero; end
      6'b110110: begin is_br = 1'b1; taken = bus.sign; end
      6'b111000: begin is_jmp = 1'b1; is_jtgt = 1'b1; end
      6'b111001: begin is_jmp = 1'b1; is_jr = 1'b1; end
      6'b111010: begin is_jmp = 1'b1; is_jtgt = 1'b1; is_jal = 1'b1; end
      6'b111111: is_halt = 1'b1;
      default: ;
    endcase
    known = is_alu | is_imm | is_sw | is_lw | is_br | is_jmp | is_halt;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      cur <= S_IF;
    end else begin
      case (cur)
        S_IF:  cur <= S_ID;
        S_ID: begin
          if (is_halt)                cur <= S_HALT;
          else if (is_jmp || !known)  cur <= S_IF;
          else                        cur <= S_EXE;
        end
        S_EXE: begin
          if (is_br)                  cur <= S_IF;
          else if (is_sw || is_lw)    cur <= S_MEM;
          else                        cur <= S_WB;
        end
        S_MEM:  cur <= is_lw ? S_WB : S_IF;
        S_WB:   cur <= S_IF;
        S_HALT: cur <= S_HALT;
        default: cur <= S_IF;
      endcase
    end
  end

  // Selects are driven only while an instruction is being executed (ID..WB).
  // PCWre fires in each instruction's final state; Reset masks every write strobe.
  always_comb begin
    bus.state     = cur;
    bus.InsMemRW  = 1'b1;
    bus.halted    = (cur == S_HALT);
    bus.IRWre     = (cur == S_IF);
    bus.PCWre     = 1'b0;
    bus.RegWre    = 1'b0;
    bus.mRD       = 1'b0;
    bus.mWR       = 1'b0;
    bus.ALUSrcA   = 1'b0;
    bus.ALUSrcB   = 1'b0;
    bus.DBDataSrc = 1'b0;
    bus.WrRegDSrc = 1'b0;
    bus.ExtSel    = 1'b0;
    bus.RegDst    = 2'b00;
    bus.PCSrc     = 2'b00;
    bus.ALUOp     = 3'b000;
    if (cur != S_IF && cur != S_HALT) begin
      bus.ALUSrcA   = is_sll;
      bus.ALUSrcB   = is_imm | is_lw | is_sw;
      bus.DBDataSrc = is_lw;
      bus.WrRegDSrc = ~is_jal;
      bus.ExtSel    = ~is_zext;
      bus.ALUOp     = alu_op;
      if (is_alu)                  bus.RegDst = 2'b10;
      else if (is_imm || is_lw)    bus.RegDst = 2'b01;
      if (is_jtgt)                 bus.PCSrc = 2'b11;
      else if (is_jr)              bus.PCSrc = 2'b10;
      else if (cur == S_EXE && is_br && taken) bus.PCSrc = 2'b01;
    end
    case (cur)
      S_ID: begin
        bus.PCWre  = is_jmp | ~known;
        bus.RegWre = is_jal;
      end
      S_EXE: bus.PCWre = is_br;
      S_MEM: begin
        bus.PCWre = is_sw;
        bus.mWR   = is_sw;
        bus.mRD   = is_lw;
      end
      S_WB: begin
        bus.PCWre  = 1'b1;
        bus.RegWre = is_alu | is_imm | is_lw;
      end
      default: ;
    endcase
    if (Reset) begin
      bus.IRWre  = 1'b0;
      bus.PCWre  = 1'b0;
      bus.RegWre = 1'b0;
      bus.mRD    = 1'b0;
      bus.mWR    = 1'b0;
    end
  end

endmodule
